// File: rtl/qspi_target.sv
// QSPI responder: oversamples the pads, deserialises command/address/data
// nibbles into local read/write strobes and serialises read data back out.
module qspi_target #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_sclk,
    input  logic                  i_cs,
    input  logic [3:0]            i_d_in,
    output logic [3:0]            o_d_out,
    output logic                  o_d_oe,
    output logic                  o_wr_valid,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [7:0]            o_wr_data,
    output logic                  o_rd_valid,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [7:0]            i_rd_data,
    output logic                  o_cmd_error
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, CMD, WADDR, WDATA, RADDR, DUMMY, RDATA, IGNORE
    } state_t;

    state_t                       r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0]       r_sclk_sync, r_cs_sync;
    logic [SYNC_STAGES-1:0][3:0]  r_d_sync;
    logic                         r_sclk_q, r_cs_q;
    logic                         r_nib;
    logic [3:0]                   r_hi;
    logic [ADDR_WIDTH-1:0]        r_addr, w_addr_nxt;
    logic                         r_rd_pend, r_cap_tx;
    logic [7:0]                   r_tx, r_pref;
    logic [1:0]                   r_txph;
    logic                         w_sclk, w_cs, w_rise, w_fall, w_cs_fall, w_byte_done;
    logic [3:0]                   w_d;
    logic [7:0]                   w_byte;
    logic                         w_wr_fire, w_rd_fire, w_err_fire, w_addr_load, w_addr_inc;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_d_sync    <= '0;
            r_sclk_q    <= 1'b0;
            r_cs_q      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
            r_d_sync    <= {r_d_sync[SYNC_STAGES-2:0], i_d_in};
            r_sclk_q    <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_q      <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_d         = r_d_sync[SYNC_STAGES-1];
    assign w_rise      = w_sclk & ~r_sclk_q;
    assign w_fall      = ~w_sclk & r_sclk_q;
    assign w_cs_fall   = ~w_cs & r_cs_q;
    // cs high masks the completing edge so an aborted byte never strobes
    assign w_byte_done = w_rise & r_nib & ~w_cs & (r_state != IDLE);
    assign w_byte      = {r_hi, w_d};
    assign w_addr_nxt  = w_addr_load ? ADDR_WIDTH'(w_byte) : r_addr + ADDR_WIDTH'(1);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_fire   = 1'b0;
        w_rd_fire   = 1'b0;
        w_err_fire  = 1'b0;
        w_addr_load = 1'b0;
        w_addr_inc  = 1'b0;
        if (w_cs) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:  if (w_cs_fall) w_state_nxt = CMD;
                CMD:   if (w_byte_done) begin
                    if (w_byte == 8'h02)      w_state_nxt = WADDR;
                    else if (w_byte == 8'h0B) w_state_nxt = RADDR;
                    else begin
                        w_err_fire  = 1'b1;
                        w_state_nxt = IGNORE;
                    end
                end
                WADDR: if (w_byte_done) begin
                    w_addr_load = 1'b1;
                    w_state_nxt = WDATA;
                end
                WDATA: if (w_byte_done) begin
                    w_wr_fire  = 1'b1;
                    w_addr_inc = 1'b1;
                end
                RADDR: if (w_byte_done) begin
                    w_addr_load = 1'b1;
                    w_rd_fire   = 1'b1;
                    w_state_nxt = DUMMY;
                end
                DUMMY: if (w_byte_done) begin
                    w_addr_inc  = 1'b1;
                    w_rd_fire   = 1'b1;
                    w_state_nxt = RDATA;
                end
                // prefetch of the following byte is issued as the current one is loaded
                RDATA: if (w_fall && r_txph == 2'd2) begin
                    w_addr_inc = 1'b1;
                    w_rd_fire  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wr_valid  <= 1'b0;
            o_rd_valid  <= 1'b0;
            o_cmd_error <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_rd_addr   <= '0;
            o_d_out     <= '0;
            o_d_oe      <= 1'b0;
            r_addr      <= '0;
            r_nib       <= 1'b0;
            r_hi        <= '0;
            r_rd_pend   <= 1'b0;
            r_cap_tx    <= 1'b0;
            r_tx        <= '0;
            r_pref      <= '0;
            r_txph      <= '0;
        end else begin
            o_wr_valid  <= w_wr_fire;
            o_rd_valid  <= w_rd_fire;
            o_cmd_error <= w_err_fire;
            if (w_wr_fire) begin
                o_wr_addr <= r_addr;
                o_wr_data <= w_byte;
            end
            if (w_rd_fire) begin
                o_rd_addr <= w_addr_nxt;
                r_cap_tx  <= (r_state == RADDR);
            end
            if (w_addr_load || w_addr_inc) r_addr <= w_addr_nxt;

            if (w_cs || r_state == IDLE) begin
                r_nib <= 1'b0;
            end else if (w_rise) begin
                r_nib <= ~r_nib;
                if (!r_nib) r_hi <= w_d;
            end

            // rd_data is valid the clock after rd_valid, i.e. while r_rd_pend is high
            r_rd_pend <= o_rd_valid;
            if (r_rd_pend) begin
                if (r_cap_tx) r_tx   <= i_rd_data;
                else          r_pref <= i_rd_data;
            end

            o_d_oe <= (w_state_nxt == RDATA);
            if (w_state_nxt != RDATA) begin
                r_txph  <= 2'd0;
                o_d_out <= '0;
            end else if (r_state == RDATA && w_fall) begin
                case (r_txph)
                    2'd0: begin
                        o_d_out <= r_tx[7:4];
                        r_txph  <= 2'd1;
                    end
                    2'd1: begin
                        o_d_out <= r_tx[3:0];
                        r_txph  <= 2'd2;
                    end
                    default: begin
                        o_d_out <= r_pref[7:4];
                        r_tx    <= r_pref;
                        r_txph  <= 2'd1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_qspi_target.sv
// Directed bench for qspi_target: write/read bursts, wrap, bad command,
// abort and mid-read reset, checked with immediate assertions.
module tb_qspi_target;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs = 1'b1;
    logic [3:0] d_in = 4'h0;
    logic [7:0] rd_data = 8'h00;
    logic [3:0] d_out;
    logic       d_oe, wr_valid, rd_valid, cmd_error;
    logic [7:0] wr_addr, wr_data, rd_addr;

    logic [7:0]  mem [256];
    logic [15:0] wr_q [$];
    logic [7:0]  rd_q [$];
    int          err_cnt = 0;
    int          multi_cnt = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    logic        oe_acc;
    logic [3:0]  x;
    logic        o;

    always #5 clk = ~clk;

    qspi_target #(.SYNC_STAGES(2), .ADDR_WIDTH(8)) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_sclk(sclk), .i_cs(cs), .i_d_in(d_in),
        .o_d_out(d_out), .o_d_oe(d_oe), .o_wr_valid(wr_valid), .o_wr_addr(wr_addr),
        .o_wr_data(wr_data), .o_rd_valid(rd_valid), .o_rd_addr(rd_addr),
        .i_rd_data(rd_data), .o_cmd_error(cmd_error)
    );

    // local memory: data appears one clock after rd_valid
    always @(posedge clk) if (rd_valid) rd_data <= mem[rd_addr];

    always @(negedge clk) begin
        if (wr_valid)  wr_q.push_back({wr_addr, wr_data});
        if (rd_valid)  rd_q.push_back(rd_addr);
        if (cmd_error) err_cnt++;
        if (int'(wr_valid) + int'(rd_valid) + int'(cmd_error) > 1) multi_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one sclk cycle; d_out/d_oe are sampled late in the low half
    task automatic nib(input logic [3:0] n, output logic [3:0] dout, output logic oe);
        d_in = n;
        wait_clk(8);
        dout = d_out;
        oe   = d_oe;
        sclk = 1'b1;
        wait_clk(8);
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [3:0] dd;
        logic       ee;
        nib(b[7:4], dd, ee);
        oe_acc = oe_acc | ee;
        nib(b[3:0], dd, ee);
        oe_acc = oe_acc | ee;
    endtask

    task automatic frame_start();
        cs = 1'b0;
        oe_acc = 1'b0;
        wait_clk(8);
    endtask

    task automatic frame_end();
        wait_clk(8);
        cs = 1'b1;
        wait_clk(8);
    endtask

    task automatic clear_q();
        wr_q.delete();
        rd_q.delete();
        err_cnt = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[8'h20] = 8'h5A;
        mem[8'h21] = 8'hC3;
        mem[8'h22] = 8'h77;

        // reset values
        wait_clk(3);
        chk("rst_doe", d_oe, 0);
        chk("rst_dout", d_out, 0);
        chk("rst_strobes", {wr_valid, rd_valid, cmd_error}, 0);
        chk("rst_wr_addr", wr_addr, 0);
        rst_n = 1'b1;
        wait_clk(4);

        // write burst
        frame_start();
        send_byte(8'h02); send_byte(8'h10); send_byte(8'hA5); send_byte(8'h3C);
        frame_end();
        chk("wb_count", wr_q.size(), 2);
        chk("wb_first", wr_q[0], 16'h10A5);
        chk("wb_second", wr_q[1], 16'h113C);
        chk("wb_oe", oe_acc, 0);
        chk("wb_idle", dut.r_state, 0);
        clear_q();

        // read burst
        frame_start();
        send_byte(8'h0B); send_byte(8'h20);
        chk("rb_oe_addr", oe_acc, 0);
        nib(4'h0, x, o); chk("rb_dummy_oe1", o, 0);
        nib(4'h0, x, o); chk("rb_dummy_oe2", o, 0);
        nib(4'h0, x, o); chk("rb_n0", x, 4'h5); chk("rb_oe_rdata", o, 1);
        nib(4'h0, x, o); chk("rb_n1", x, 4'hA);
        nib(4'h0, x, o); chk("rb_n2", x, 4'hC);
        wait_clk(8);
        chk("rb_n3", d_out, 4'h3);
        cs = 1'b1;
        wait_clk(16);
        chk("rb_oe_end", d_oe, 0);
        chk("rb_rd_count", rd_q.size(), 3);
        chk("rb_rd0", rd_q[0], 8'h20);
        chk("rb_rd1", rd_q[1], 8'h21);
        chk("rb_rd2", rd_q[2], 8'h22);
        chk("rb_no_wr", wr_q.size(), 0);
        clear_q();

        // address wrap
        frame_start();
        send_byte(8'h02); send_byte(8'hFF); send_byte(8'h11); send_byte(8'h22);
        frame_end();
        chk("wrap_count", wr_q.size(), 2);
        chk("wrap_first", wr_q[0], 16'hFF11);
        chk("wrap_second", wr_q[1], 16'h0022);
        clear_q();

        // bad command, then a fresh good frame
        frame_start();
        send_byte(8'h7E); send_byte(8'h02); send_byte(8'h55); send_byte(8'h0B);
        frame_end();
        chk("bad_err", err_cnt, 1);
        chk("bad_no_wr", wr_q.size(), 0);
        chk("bad_no_rd", rd_q.size(), 0);
        frame_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h99);
        frame_end();
        chk("bad_next_count", wr_q.size(), 1);
        chk("bad_next_wr", wr_q[0], 16'h0099);
        chk("bad_next_err", err_cnt, 1);
        clear_q();

        // abort after first nibble of a data byte
        frame_start();
        send_byte(8'h02); send_byte(8'h40);
        nib(4'h6, x, o);
        frame_end();
        chk("abort_no_wr", wr_q.size(), 0);
        chk("abort_idle", dut.r_state, 0);
        chk("abort_oe", d_oe, 0);
        clear_q();

        // async reset in RDATA between sclk edges
        frame_start();
        send_byte(8'h0B); send_byte(8'h20);
        nib(4'h0, x, o); nib(4'h0, x, o);
        nib(4'h0, x, o);
        wait_clk(5);
        chk("pre_rst_dout", d_out, 4'hA);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_oe", d_oe, 0);
        chk("mid_rst_dout", d_out, 0);
        chk("mid_rst_strobes", {wr_valid, rd_valid, cmd_error}, 0);
        cs = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(8);
        clear_q();
        frame_start();
        send_byte(8'h0B); send_byte(8'h20);
        nib(4'h0, x, o); nib(4'h0, x, o);
        nib(4'h0, x, o); chk("post_rst_n0", x, 4'h5);
        nib(4'h0, x, o); chk("post_rst_n1", x, 4'hA);
        frame_end();
        chk("post_rst_rd0", rd_q[0], 8'h20);
        chk("post_rst_oe", d_oe, 0);

        chk("one_strobe", multi_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
